serial_adder_accum: RTL and testbench
=====================================

Name: serial_adder_accum

Overview:
- Parametrised sequential successor to the single-bit full adder.
- Adds two WIDTH-bit operands bit-serially, one full-adder slice per clock, LSB first. Carry is held in a register between cycles.
- Optional accumulate mode adds the operand to the running sum.
- Valid/ready handshake on input and output, so it can sit between arithmetic test harnesses and datapath blocks.

Parameters:
- WIDTH, 8, operand and sum width in bits (>=2).
- CNT_W, $clog2(WIDTH), width of the bit-position counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present on a, b, cin.
- in_ready  output  1  block idle and can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored in accumulate mode).
- cin  input  1  carry-in to bit 0.
- acc_mode  input  1  sampled with the operand: 1 = sum <= acc + a, 0 = sum <= a + b.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  serial add in progress.

Behaviour:
- One clock domain; reset is asynchronous, active-low on rst_n.
- Reset values: in_ready=1, out_valid=0, busy=0, s=0, cout=0, accumulator=0, counter=0, FSM=IDLE.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid && in_ready, capture into shift registers:
    - opA = a;
    - opB = acc_mode ? accumulator : b;
    - carry reg = cin; counter = 0.
  - Go to RUN.
- RUN:
  - Each cycle compute a full-adder slice on opA[0], opB[0] and carry:
    - sum bit = xor of the three;
    - carry = majority of the three.
  - Shift the sum bit into the sum register MSB, then shift right. Shift opA and opB right.
  - Counter increments.
  - When counter==WIDTH-1 this cycle, go to DONE.
- DONE:
  - out_valid=1; s and cout are held stable.
  - Accumulator is loaded with s on entry to DONE.
  - On out_valid && out_ready, return to IDLE.
- Latency: WIDTH+1 cycles from the input handshake to out_valid. Throughput is one add per WIDTH+2 cycles minimum.
- in_ready=0 in RUN and DONE. in_valid during those states is ignored; it is not queued.
- busy=1 only in RUN.
- Overflow wraps modulo 2^WIDTH; the carry out goes to cout.
- Accumulator is unsigned and also wraps.
- s and cout change only on entry to DONE. They keep their previous values in IDLE and RUN.
- Back-pressure: DONE holds indefinitely while out_ready=0.
- Reset mid-RUN: the partial result is discarded, all outputs return to reset values and the accumulator clears.
- With out_ready tied to 1, DONE lasts exactly one cycle.

Optional Feature:
- Macro SERIAL_ADDER_CLR_EN.
- Defined: adds input port acc_clr (1 bit).
  - acc_clr=1 in IDLE zeroes the accumulator next cycle.
  - If acc_clr and an in_valid handshake occur in the same cycle, the clear applies first, so opB = 0.
  - acc_clr is ignored in RUN and DONE.
- Undefined: no port; the accumulator clears only on reset.

Test Plan:
- Exhaustive 3-bit slice check:
  - Stimulus: WIDTH=8, acc_mode=0, a,b in {0,1} at bit 0, cin in {0,1}, all 8 combinations.
  - Required: s[0] and the carry into s[1] match the full-adder truth table. Example: a=1, b=1, cin=1 gives s=3, cout=0.
- Overflow:
  - Stimulus: a=8'hFF, b=8'h01, cin=0.
  - Required: out_valid exactly 9 cycles after the handshake, s=8'h00, cout=1.
- Accumulate:
  - Stimulus: after reset, three accumulate-mode ops with a=8'h40, cin=0.
  - Required: s=40, 80, C0, cout=0 each time. A fourth op with a=8'h40 gives s=00, cout=1.
- Back-pressure and ignored input:
  - Stimulus: out_ready=0 for 5 cycles after out_valid; assert in_valid during RUN and DONE.
  - Required: s stable, in_ready=0, no extra result produced.
- Reset mid-operation:
  - Stimulus: drop rst_n 3 cycles into RUN.
  - Required: out_valid=0, s=0, in_ready=1 immediately. The next add of 5+3 yields 8.
- SERIAL_ADDER_CLR_EN:
  - Stimulus: accumulate 8'h10, then pulse acc_clr together with an accumulate op of a=8'h05.
  - Required: s=8'h05.

Source files
------------

// File: rtl/serial_adder_accum.sv
// serial_adder_accum: bit-serial WIDTH-bit adder with an optional accumulate mode.
// One full-adder slice is evaluated per clock, LSB first, and the carry is held
// in a register between slices. Valid/ready handshakes on both sides.
//
// Build option: define SERIAL_ADDER_CLR_EN to add the acc_clr input, which
// zeroes the accumulator from IDLE. Without it the accumulator clears only on
// reset.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | in_ready=1, waiting for an operand handshake
// RUN     | busy=1, one full-adder slice per cycle, WIDTH cycles in total
// DONE    | out_valid=1, result held until out_ready
module serial_adder_accum #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             acc_mode,
`ifdef SERIAL_ADDER_CLR_EN
  input  logic             acc_clr,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic [WIDTH-1:0] r_acc;

  logic             w_take;
  logic             w_clr;
  logic             w_last;
  logic             w_sum_bit;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] w_sum_word;
  logic [WIDTH-1:0] w_opb_load;

  // Handshake and clear qualifiers; a clear only has effect from IDLE.
  assign w_take = in_valid && (r_state == ST_IDLE);
`ifdef SERIAL_ADDER_CLR_EN
  assign w_clr  = acc_clr && (r_state == ST_IDLE);
`else
  assign w_clr  = 1'b0;
`endif

  // A clear in the same cycle as the handshake wins, so accumulate sees zero.
  assign w_opb_load = acc_mode ? (w_clr ? '0 : r_acc) : b;

  // One full-adder slice on the current LSBs and the held carry.
  assign w_sum_bit   = r_opa[0] ^ r_opb[0] ^ r_carry;
  assign w_carry_nxt = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_carry) | (r_opb[0] & r_carry);

  // Complete sum word once the final bit is shifted into the MSB.
  assign w_sum_word = {w_sum_bit, r_sum_sh[WIDTH-1:1]};

  assign w_last = (r_state == ST_RUN) && (r_cnt == LAST_BIT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_take) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand capture, serial slice datapath, result and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum_sh <= '0;
      r_s      <= '0;
      r_cout   <= 1'b0;
      r_acc    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_opa   <= a;
            r_opb   <= w_opb_load;
            r_carry <= cin;
            r_cnt   <= '0;
          end
          if (w_clr) begin
            r_acc <= '0;
          end
        end
        ST_RUN: begin
          r_sum_sh <= w_sum_word;
          r_opa    <= r_opa >> 1;
          r_opb    <= r_opb >> 1;
          r_carry  <= w_carry_nxt;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_s    <= w_sum_word;
            r_cout <= w_carry_nxt;
            r_acc  <= w_sum_word;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_RUN);
  assign out_valid = (r_state == ST_DONE);
  assign s         = r_s;
  assign cout      = r_cout;

endmodule

// File: tb/tb_serial_adder_accum.sv
// Self-checking bench for serial_adder_accum: directed literal cases plus a
// randomized phase, all compared every cycle against an arithmetic model.
module tb_serial_adder_accum;

  localparam int W = 8;

`ifdef SERIAL_ADDER_CLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         acc_mode = 1'b0;
  logic         acc_clr = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         cout;
  logic         busy;

  int n_cmp = 0;
  int n_mis = 0;

  // Behavioural model: a result appears W+1 cycles after the handshake.
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_s = '0;
  logic         m_cout = 1'b0;
  logic [W-1:0] m_acc = '0;
  logic [W:0]   m_pend = '0;
  int           m_results = 0;
  int           dut_results = 0;

  serial_adder_accum #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .acc_mode  (acc_mode),
`ifdef SERIAL_ADDER_CLR_EN
    .acc_clr   (acc_clr),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update on each rising edge or asynchronous reset.
  initial begin
    logic [W-1:0] opnd;
    bit           clr;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_left = 0;
        m_done = 1'b0;
        m_s    = '0;
        m_cout = 1'b0;
        m_acc  = '0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_s    = m_pend[W-1:0];
          m_cout = m_pend[W];
          m_acc  = m_s;
          m_results++;
        end
      end else if (m_done) begin
        if (out_ready) m_done = 1'b0;
      end else begin
        clr = CLR_EN && acc_clr;
        if (in_valid) begin
          opnd   = acc_mode ? (clr ? '0 : m_acc) : b;
          m_pend = {1'b0, a} + {1'b0, opnd} + {{W{1'b0}}, cin};
          m_left = W;
        end
        if (clr) m_acc = '0;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    bit prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("cyc in_ready", 32'(in_ready), 32'((m_left == 0) && !m_done));
        chk("cyc busy", 32'(busy), 32'(m_left > 0));
        chk("cyc out_valid", 32'(out_valid), 32'(m_done));
        chk("cyc s", 32'(s), 32'(m_s));
        chk("cyc cout", 32'(cout), 32'(m_cout));
        if (out_valid === 1'b1 && !prev_ov) dut_results++;
        prev_ov = (out_valid === 1'b1);
      end else begin
        prev_ov = 1'b0;
      end
    end
  end

  // One handshake, then check latency, literal result and single-cycle DONE.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                        input logic tm, input logic tclr, input logic [W-1:0] es,
                        input logic ec, input string nm);
    int cyc;
    @(negedge clk);
    chk({nm, " idle"}, 32'(in_ready), 32'd1);
    a = ta; b = tbv; cin = tc; acc_mode = tm; acc_clr = tclr;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; acc_clr = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " latency"}, 32'(cyc), 32'(W + 1));
    chk({nm, " s"}, 32'(s), 32'(es));
    chk({nm, " cout"}, 32'(cout), 32'(ec));
    @(negedge clk);
    chk({nm, " done one cycle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] sum_tab;
    logic [7:0] car_tab;
    logic [2:0] idx;
    int         cyc;
    sum_tab = 8'b1001_0110;
    car_tab = 8'b1110_1000;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset s", 32'(s), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);

    run_op(8'h40, 8'h00, 1'b0, 1'b1, 1'b0, 8'h40, 1'b0, "acc1");
    run_op(8'h40, 8'h00, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, "acc2");
    run_op(8'h40, 8'h00, 1'b0, 1'b1, 1'b0, 8'hC0, 1'b0, "acc3");
    run_op(8'h40, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, "acc4");

    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      run_op({7'd0, idx[2]}, {7'd0, idx[1]}, idx[0], 1'b0, 1'b0,
             {6'd0, car_tab[idx], sum_tab[idx]}, 1'b0, $sformatf("slice%0d", i));
    end

    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "overflow");

    // Back-pressure with in_valid held during RUN and DONE.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; acc_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      cyc++;
    end while (out_valid !== 1'b1 && cyc < 40);
    chk("bp reached done", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp s stable", 32'(s), 32'h46);
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp held", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp released", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("bp no extra", 32'(busy), 32'd0);

    // Reset three cycles into RUN.
    @(negedge clk);
    a = 8'h77; b = 8'h11; acc_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst s", 32'(s), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0, "after reset");

`ifdef SERIAL_ADDER_CLR_EN
    run_op(8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 8'h18, 1'b0, "clr acc");
    run_op(8'h05, 8'h00, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0, "clr op");
`endif

    // Randomized phase; the per-cycle compare does the checking.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 2) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom_range(0, 1));
      acc_mode  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      acc_clr   = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk("result count", 32'(dut_results), 32'(m_results));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    n_mis++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "watchdog");
  end

endmodule
